// File: rtl/mem_wb_if.sv
// mem_wb_if: bundle of the handshake and data signals between the MEM stage,
// the MEM/WB pipeline stage and register-file write-back.
//
// Ports / signals (parameterised by DATA_W, REG_ADDR_W):
//   MEM side    : in_valid, in_ready, ALUResult, dataMemOut, RegWrite,
//                 MemToReg, WriteRegister, flush
//   WB side     : wb_valid, wb_ready, ALUResult_WB, dataMemOut_WB,
//                 RegWrite_WB, MemToReg_WB, WriteRegister_WB, WriteData_WB
//   Debug       : dbg_state ({main_valid, skid_valid})
//
// Modports:
//   slave  - the pipeline stage itself
//   master - the environment (MEM stage source + WB sink)
//
// Handshake: a transfer happens on a rising Clk edge where valid and ready
// are both high. A valid source holds its data stable until the transfer;
// ready may be high or low independently of valid.
interface mem_wb_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     ALUResult;
  logic [DATA_W-1:0]     dataMemOut;
  logic                  RegWrite;
  logic                  MemToReg;
  logic [REG_ADDR_W-1:0] WriteRegister;
  logic                  flush;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [DATA_W-1:0]     ALUResult_WB;
  logic [DATA_W-1:0]     dataMemOut_WB;
  logic                  RegWrite_WB;
  logic                  MemToReg_WB;
  logic [REG_ADDR_W-1:0] WriteRegister_WB;
  logic [DATA_W-1:0]     WriteData_WB;
  logic [1:0]            dbg_state;

  modport slave (
    input  in_valid, ALUResult, dataMemOut, RegWrite, MemToReg, WriteRegister,
           flush, wb_ready,
    output in_ready, wb_valid, ALUResult_WB, dataMemOut_WB, RegWrite_WB,
           MemToReg_WB, WriteRegister_WB, WriteData_WB, dbg_state
  );

  modport master (
    output in_valid, ALUResult, dataMemOut, RegWrite, MemToReg, WriteRegister,
           flush, wb_ready,
    input  in_ready, wb_valid, ALUResult_WB, dataMemOut_WB, RegWrite_WB,
           MemToReg_WB, WriteRegister_WB, WriteData_WB, dbg_state
  );
endinterface

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: MEM/WB pipeline register with a valid/ready handshake
// and a 2-entry skid buffer (main + skid), synchronous flush, valid-gated
// write enable and the write-back data mux.
//
// Ports:
//   Clk            - clock, all state on posedge
//   reset          - synchronous, active-high
//   bus (slave)    - mem_wb_if: MEM-side inputs, WB-side outputs, dbg_state
//   stall_cycles   - (MEM_WB_PERF_EN only) cycles with wb_valid & !wb_ready
//   bubble_cycles  - (MEM_WB_PERF_EN only) cycles with !wb_valid, not reset
//
// Optional feature: define MEM_WB_PERF_EN to add the two saturating
// performance counters (CNT_W bits each).
//
// The main entry always drives the *_WB outputs; the skid entry only holds
// the instruction accepted while WB was stalled. in_ready is registered so
// the MEM stage never sees a combinational path from wb_ready.
module mem_wb_pipe_stage #(
  parameter int DATA_W        = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int ZERO_REG_GATE = 1,
  parameter int CNT_W         = 16
) (
  input  logic Clk,
  input  logic reset,
  mem_wb_if.slave bus
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cycles
`endif
);

  // Encoding is {main_valid, skid_valid}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } state_t;

  state_t state_q, state_n;
  logic   in_ready_q;

  logic [DATA_W-1:0]     main_alu_q, main_mem_q, skid_alu_q, skid_mem_q;
  logic                  main_rw_q, main_m2r_q, skid_rw_q, skid_m2r_q;
  logic [REG_ADDR_W-1:0] main_wr_q, skid_wr_q;

  logic main_valid;
  logic accept, pop;
  logic load_main_in, load_main_skid, load_skid;
  logic dst_ok;

  assign main_valid = state_q[1];
  assign accept     = bus.in_valid & in_ready_q;
  assign pop        = main_valid & bus.wb_ready;

  // Next-state and load selection.
  always_comb begin
    state_n        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_n      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_n   = ST_TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_n = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_n        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    // Flush drops everything, including whatever is offered this cycle.
    // Data fields are left stale; only the valid bits matter.
    if (bus.flush) begin
      state_n        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // State, ready and data registers.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_alu_q <= '0;
      main_mem_q <= '0;
      main_rw_q  <= 1'b0;
      main_m2r_q <= 1'b0;
      main_wr_q  <= '0;
      skid_alu_q <= '0;
      skid_mem_q <= '0;
      skid_rw_q  <= 1'b0;
      skid_m2r_q <= 1'b0;
      skid_wr_q  <= '0;
    end else begin
      state_q    <= state_n;
      in_ready_q <= ~state_n[0];
      if (load_main_in) begin
        main_alu_q <= bus.ALUResult;
        main_mem_q <= bus.dataMemOut;
        main_rw_q  <= bus.RegWrite;
        main_m2r_q <= bus.MemToReg;
        main_wr_q  <= bus.WriteRegister;
      end else if (load_main_skid) begin
        main_alu_q <= skid_alu_q;
        main_mem_q <= skid_mem_q;
        main_rw_q  <= skid_rw_q;
        main_m2r_q <= skid_m2r_q;
        main_wr_q  <= skid_wr_q;
      end
      if (load_skid) begin
        skid_alu_q <= bus.ALUResult;
        skid_mem_q <= bus.dataMemOut;
        skid_rw_q  <= bus.RegWrite;
        skid_m2r_q <= bus.MemToReg;
        skid_wr_q  <= bus.WriteRegister;
      end
    end
  end

  // Writes to register 0 are suppressed when the gate is enabled.
  assign dst_ok = (ZERO_REG_GATE == 0) || (main_wr_q != '0);

  // Outputs.
  always_comb begin
    bus.in_ready         = in_ready_q;
    bus.wb_valid         = main_valid;
    bus.ALUResult_WB     = main_alu_q;
    bus.dataMemOut_WB    = main_mem_q;
    bus.MemToReg_WB      = main_m2r_q;
    bus.WriteRegister_WB = main_wr_q;
    bus.RegWrite_WB      = main_rw_q & main_valid & dst_ok;
    bus.WriteData_WB     = main_m2r_q ? main_mem_q : main_alu_q;
    bus.dbg_state        = state_q;
  end

`ifdef MEM_WB_PERF_EN
  // Saturating counters; flush does not clear them.
  always_ff @(posedge Clk) begin
    if (reset) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (main_valid && !bus.wb_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (!main_valid && (bubble_cycles != '1))
        bubble_cycles <= bubble_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: reset checks, a vector table, hand-written
// back-pressure / streaming / perf sequences and a randomized run checked
// against a queue model of the stage's contents.
module tb_mem_wb_pipe_stage;
  localparam int DATA_W = 32;
  localparam int AW     = 5;
  localparam int CNT_W  = 4;
  localparam int E_W    = 2 * DATA_W + 2 + AW;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  mem_wb_if #(.DATA_W(DATA_W), .REG_ADDR_W(AW)) bus ();

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0] stall_cycles, bubble_cycles;
`endif

  mem_wb_pipe_stage #(
    .DATA_W(DATA_W), .REG_ADDR_W(AW), .ZERO_REG_GATE(1), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .bus(bus)
`ifdef MEM_WB_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .bubble_cycles(bubble_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // Entries held by the stage, oldest first: {alu, mem, rw, m2r, wr}.
  logic [E_W-1:0] exp_q[$];
  logic m_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, updates the model at the edge, then checks
  // the outputs 1 time unit after the edge.
  task automatic step(input logic rst, input logic iv, input logic [DATA_W-1:0] alu,
                      input logic [DATA_W-1:0] mem, input logic rw, input logic m2r,
                      input logic [AW-1:0] wr, input logic wbr, input logic fl);
    logic [E_W-1:0] e;
    logic acc, pp;
    reset             = rst;
    bus.in_valid      = iv;
    bus.ALUResult     = alu;
    bus.dataMemOut    = mem;
    bus.RegWrite      = rw;
    bus.MemToReg      = m2r;
    bus.WriteRegister = wr;
    bus.wb_ready      = wbr;
    bus.flush         = fl;
    @(posedge Clk);
    if (rst) begin
      exp_q.delete();
      m_ready = 1'b0;
    end else if (fl) begin
      exp_q.delete();
      m_ready = 1'b1;
    end else begin
      acc = iv & m_ready;
      pp  = (exp_q.size() > 0) & wbr;
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({alu, mem, rw, m2r, wr});
      m_ready = (exp_q.size() < 2);
    end
    #1;
    chk("wb_valid", 64'(bus.wb_valid), 64'(exp_q.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("alu_wb", 64'(bus.ALUResult_WB), 64'(e[E_W-1 -: DATA_W]));
      chk("mem_wb", 64'(bus.dataMemOut_WB), 64'(e[AW+2 +: DATA_W]));
      chk("wr_wb", 64'(bus.WriteRegister_WB), 64'(e[AW-1:0]));
      chk("m2r_wb", 64'(bus.MemToReg_WB), 64'(e[AW]));
      chk("regwrite_wb", 64'(bus.RegWrite_WB), 64'(e[AW+1] && (e[AW-1:0] != 0)));
      chk("writedata_wb", 64'(bus.WriteData_WB),
          64'(e[AW] ? e[AW+2 +: DATA_W] : e[E_W-1 -: DATA_W]));
    end else begin
      chk("regwrite_idle", 64'(bus.RegWrite_WB), 64'(0));
    end
  endtask

  task automatic idle(input logic wbr);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, wbr, 1'b0);
  endtask

  task automatic push(input logic [DATA_W-1:0] alu, input logic wbr);
    step(1'b0, 1'b1, alu, '0, 1'b1, 1'b0, AW'(3), wbr, 1'b0);
  endtask

  // Two reset cycles with reset-value checks, then release.
  task automatic apply_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, '1, 1'b1, 1'b0);
      chk("rst_alu_wb", 64'(bus.ALUResult_WB), 64'(0));
      chk("rst_writedata_wb", 64'(bus.WriteData_WB), 64'(0));
      chk("rst_state", 64'(bus.dbg_state), 64'(0));
    end
    idle(1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic              rw;
    logic              m2r;
    logic [AW-1:0]     wr;
    logic              wbr;
    logic              fl;
    logic              e_wbv;
    logic              e_rdy;
    logic [DATA_W-1:0] e_alu;
    logic              e_rw;
    logic [DATA_W-1:0] e_wd;
  } vec_t;

  vec_t vecs[10];
  logic [DATA_W-1:0] got[8];
  int nvalid;

  initial begin
    // in: iv alu mem rw m2r wr wbr fl | exp: wbv rdy alu rw wd
    vecs[0] = '{1, 32'h10, 32'h0,        1, 0, 5, 1, 0,  1, 1, 32'h10, 1, 32'h10};
    vecs[1] = '{1, 32'h11, 32'hAA,       1, 1, 0, 1, 0,  1, 1, 32'h11, 0, 32'hAA};
    vecs[2] = '{1, 32'h22, 32'hBB,       0, 0, 7, 0, 0,  1, 0, 32'h11, 0, 32'hAA};
    vecs[3] = '{1, 32'h33, 32'hCC,       1, 0, 8, 0, 0,  1, 0, 32'h11, 0, 32'hAA};
    vecs[4] = '{0, 32'h0,  32'h0,        0, 0, 0, 1, 0,  1, 1, 32'h22, 0, 32'h22};
    vecs[5] = '{0, 32'h0,  32'h0,        0, 0, 0, 1, 0,  0, 1, 32'h22, 0, 32'h22};
    vecs[6] = '{1, 32'h44, 32'hDEADBEEF, 1, 1, 0, 0, 0,  1, 1, 32'h44, 0, 32'hDEADBEEF};
    vecs[7] = '{1, 32'h55, 32'h0,        1, 0, 9, 0, 0,  1, 0, 32'h44, 0, 32'hDEADBEEF};
    vecs[8] = '{1, 32'h66, 32'h0,        1, 0, 4, 1, 1,  0, 1, 32'h44, 0, 32'hDEADBEEF};
    vecs[9] = '{0, 32'h0,  32'h0,        0, 0, 0, 1, 0,  0, 1, 32'h44, 0, 32'hDEADBEEF};

    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_ready = 1'b0;
    reset        = 1'b1;

    apply_reset();
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].iv, vecs[i].alu, vecs[i].mem, vecs[i].rw, vecs[i].m2r,
           vecs[i].wr, vecs[i].wbr, vecs[i].fl);
      chk($sformatf("vec%0d_wb_valid", i), 64'(bus.wb_valid), 64'(vecs[i].e_wbv));
      chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_alu_wb", i), 64'(bus.ALUResult_WB), 64'(vecs[i].e_alu));
      chk($sformatf("vec%0d_regwrite_wb", i), 64'(bus.RegWrite_WB), 64'(vecs[i].e_rw));
      chk($sformatf("vec%0d_writedata_wb", i), 64'(bus.WriteData_WB), 64'(vecs[i].e_wd));
    end

    // Back-pressure: A then B with WB stalled, then release.
    apply_reset();
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    chk("bp_ready_low", 64'(bus.in_ready), 64'(0));
    chk("bp_head_a", 64'(bus.ALUResult_WB), 64'(32'h11));
    idle(1'b1);
    chk("bp_head_b", 64'(bus.ALUResult_WB), 64'(32'h22));
    chk("bp_ready_back", 64'(bus.in_ready), 64'(1));
    idle(1'b1);
    chk("bp_drained", 64'(bus.wb_valid), 64'(0));

    // Streaming 8 back-to-back with WB always ready.
    apply_reset();
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      push(32'h100 + 32'(i), 1'b1);
      if (bus.wb_valid) nvalid++;
      got[i] = bus.ALUResult_WB;
    end
    chk("stream_valid_cycles", 64'(nvalid), 64'(8));
    for (int i = 0; i < 8; i++) chk($sformatf("stream_order%0d", i), 64'(got[i]), 64'(32'h100 + i));
    idle(1'b1);

    // Flush while holding two entries with a third offered.
    push(32'hA, 1'b0);
    push(32'hB, 1'b0);
    step(1'b0, 1'b1, 32'hC, 32'h0, 1'b1, 1'b0, AW'(3), 1'b1, 1'b1);
    chk("flush_wb_valid", 64'(bus.wb_valid), 64'(0));
    chk("flush_in_ready", 64'(bus.in_ready), 64'(1));
    idle(1'b1);
    chk("flush_no_c", 64'(bus.wb_valid), 64'(0));

`ifdef MEM_WB_PERF_EN
    apply_reset();
    push(32'h77, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("stall_saturate", 64'(stall_cycles), 64'(15));
    apply_reset();
    chk("stall_reset", 64'(stall_cycles), 64'(0));
`endif

    // Randomized traffic against the queue model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 29) == 0));
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/mem_wb_pipe_stage.md
Name: mem_wb_pipe_stage

Overview:
Parametrised successor to the fixed MEM/WB latch. Adds width parameters, a valid/ready handshake with a 2-entry skid buffer so WB back-pressure never drops an instruction, synchronous flush, and valid-gated write-enable. Sits between the MEM stage and register-file write-back. Also produces the write-back mux result.

Parameters:
DATA_W, 32, width of ALUResult / dataMemOut / WriteData_WB
REG_ADDR_W, 5, width of WriteRegister
ZERO_REG_GATE, 1, when 1, RegWrite_WB is forced low if WriteRegister_WB == 0
CNT_W, 16, width of performance counters (optional feature only)

Ports:
Clk  in  1  single clock, all state on posedge
reset  in  1  synchronous, active-high
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept; registered, equals !skid_valid
ALUResult  in  DATA_W  ALU result from MEM
dataMemOut  in  DATA_W  load data from MEM
RegWrite  in  1  register write enable from MEM
MemToReg  in  1  write-back select from MEM
WriteRegister  in  REG_ADDR_W  destination register
flush  in  1  discard all held and offered entries
wb_valid  out  1  main entry valid toward WB
wb_ready  in  1  WB consumes main entry
ALUResult_WB  out  DATA_W  held ALU result
dataMemOut_WB  out  DATA_W  held load data
RegWrite_WB  out  1  effective write enable (gated)
MemToReg_WB  out  1  held select
WriteRegister_WB  out  REG_ADDR_W  held destination
WriteData_WB  out  DATA_W  MemToReg_WB ? dataMemOut_WB : ALUResult_WB (combinational from held regs)

Behaviour:
- Storage: main entry (drives *_WB outputs) and skid entry, each with a valid bit. wb_valid = main_valid.
- accept = in_valid & in_ready; pop = wb_valid & wb_ready.
- States by {main_valid, skid_valid}:
  EMPTY: accept -> ONE (load main).
  ONE: accept & pop -> ONE (main <= input); accept & !pop -> TWO (skid <= input); pop & !accept -> EMPTY; neither -> hold.
  TWO: in_ready = 0, so no accept; pop -> ONE (main <= skid); else hold.
- Latency: accept into EMPTY -> wb_valid and data visible next cycle (1 cycle, same as the old latch).
- Order strictly preserved; no entry is ever duplicated or dropped except on flush/reset.
- in_ready is registered: it is high the cycle after skid empties. Max sustained throughput is 1 per cycle with wb_ready held high.
- RegWrite_WB = main_RegWrite & main_valid & (ZERO_REG_GATE ? WriteRegister_WB != 0 : 1).
- Invalid entries keep their stale data fields. Only the valid bits and RegWrite gating change.
- Flush (sync, below reset in priority): next cycle main_valid = skid_valid = 0, in_ready = 1. Any input offered in the flush cycle is discarded. A pop in the same cycle still counts as consumed by WB.
- Reset: all data registers 0, both valids 0, in_ready 0 while reset is high and 1 on the first cycle after release. RegWrite_WB = 0, WriteData_WB = 0. Reset mid-transfer discards all entries.
- Simultaneous flush + accept + pop: flush wins; stage ends EMPTY.

Optional Feature:
Macro MEM_WB_PERF_EN.
- Defined: adds outputs stall_cycles and bubble_cycles, each CNT_W wide.
  - stall_cycles increments on cycles where wb_valid & !wb_ready.
  - bubble_cycles increments on cycles where !wb_valid and not in reset.
  - Both saturate at all-ones and clear on reset (not on flush).
- Not defined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset then in_valid=1, ALUResult=0x00000010, RegWrite=1, WriteRegister=5, wb_ready=1 -> next cycle wb_valid=1, ALUResult_WB=0x10, RegWrite_WB=1, WriteData_WB=0x10.
- Back-pressure: wb_ready=0, push A=0x11, B=0x22 on consecutive cycles -> in_ready=0 the cycle after B. Release wb_ready -> outputs A then B in order, in_ready returns to 1.
- Streaming 8 instructions with wb_ready=1 -> 8 consecutive wb_valid cycles, no gaps, values match in order.
- Flush while TWO (A, B held) with C offered -> next cycle wb_valid=0, in_ready=1; C never appears at the output.
- ZERO_REG_GATE=1, RegWrite=1, WriteRegister=0, MemToReg=1, dataMemOut=0xDEADBEEF -> RegWrite_WB=0, WriteData_WB=0xDEADBEEF.
- MEM_WB_PERF_EN, CNT_W=4: hold wb_valid with wb_ready=0 for 20 cycles -> stall_cycles saturates at 15; reset clears it to 0.
